shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Multicycle sequencer for the shift datapath: shift-amount mux (ShiftN) feeding the shift
//  register (RegDesloc). Accepts one shift instruction (SLL/SRL/SRA/SLLV/SRAV/LUI) from main control.
//  Steers the mux selector, then issues load and shift commands to RegDesloc.
//  Pulses register-file write on completion; main control waits on done.
// PARAMETERS
//  SETTLE   0  extra wait cycles between LOAD and SHIFT (0..3); holds shift_ctrl=000
//  CTRL_W   3  width of RegDesloc command bus
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  req_valid   in   1       shift request valid
//  req_ready   out  1       block can accept a request (high only in IDLE)
//  req_op      in   3       000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRAV, 101 LUI, 11x illegal
//  flush       in   1       synchronous abort; returns to IDLE, no write
//  shift_sel   out  2       ShiftN selector: 10 = shamt, 11 = rs[4:0], 0x = constant 16
//  shift_ctrl  out  CTRL_W  RegDesloc command: 000 nop, 001 load, 010 left, 011 right logical, 100 right arith
//  reg_wr      out  1       register-file write strobe for RegDesloc output
//  done        out  1       one-cycle completion pulse
//  illegal     out  1       one-cycle pulse: illegal req_op accepted
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; shift_sel=00, shift_ctrl=000, reg_wr=0, done=0, illegal=0.
//    req_ready=1 once reset deasserts.
//  - Accept when req_valid & req_ready (IDLE only); req_op latched. Later changes to req_op ignored.
//  - Decode at accept:
//    - SLL -> sel=10, cmd=010; SRL -> 10/011; SRA -> 10/100.
//    - SLLV -> 11/010; SRAV -> 11/100.
//    - LUI -> 00/010 (shift left 16).
//  - FSM: IDLE -> LOAD -> SETTLE (SETTLE cycles, skipped if 0) -> SHIFT -> DONE -> IDLE.
//    - LOAD: shift_ctrl=001, shift_sel=decoded.
//    - SETTLE: shift_ctrl=000, sel held.
//    - SHIFT: shift_ctrl=decoded cmd, sel held.
//    - DONE: shift_ctrl=000, reg_wr=1, done=1, sel held.
//    - IDLE: shift_sel=00, shift_ctrl=000.
//  - Latency: accept at edge N -> LOAD in cycle N+1 -> done high in cycle N+3+SETTLE.
//    Next accept no earlier than N+4+SETTLE (req_ready=0 from LOAD through DONE).
//  - Illegal op (11x): accepted; next cycle illegal=1, state stays IDLE. No LOAD, no reg_wr, no done.
//  - shift_sel is stable from LOAD through DONE (the mux output must not glitch mid-op).
//  - All outputs are registered or decoded from state only; no combinational path from
//    req_valid/req_op to any output except none (req_ready depends on state only).
//  - flush=1 in any non-IDLE state: next state IDLE; same cycle suppresses reg_wr/done if in DONE.
//    flush in IDLE: no effect on accept (accept wins; flush is ignored in IDLE).
//  - reset low mid-operation: immediate return to reset values; the pending op is lost and no done is issued.
//  - A SETTLE counter saturates; values >3 are clamped to 3.
// TESTING
//  1. SLL, SETTLE=0, accept at cycle 0 -> c1 sel=10 ctrl=001; c2 ctrl=010; c3 done=reg_wr=1 ctrl=000; c4 ready=1.
//  2. LUI then SRAV back-to-back (valid held) -> LUI sel=00/ctrl 010, done c3; SRAV accepted c4, sel=11, ctrl=100 at c6, done c7.
//  3. req_op=110 -> illegal=1 at c1; shift_ctrl stays 000; reg_wr/done never asserted; ready=1 at c1.
//  4. SETTLE=2, SRL -> LOAD c1, nop c2-c3, ctrl=011 at c4, done c5; shift_sel=10 held c1-c5.
//  5. flush asserted in SHIFT (c2) for SLLV -> IDLE at c3, no done/reg_wr; new request accepted at c3.
//  6. reset low async during LOAD -> all outputs to reset values before next edge; after release, ready=1, no done.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multicycle sequencer driving the ShiftN selector and RegDesloc commands for one shift op.
module shift_seq_ctrl #(
  parameter int SETTLE = 0,
  parameter int CTRL_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic [2:0]        i_req_op,
  input  logic              i_flush,
  output logic              o_req_ready,
  output logic [1:0]        o_shift_sel,
  output logic [CTRL_W-1:0] o_shift_ctrl,
  output logic              o_reg_wr,
  output logic              o_done,
  output logic              o_illegal
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, DONE} state_t;
  localparam logic [1:0] SET_N = (SETTLE > 3) ? 2'd3 : 2'(SETTLE);
  state_t            r_state;
  logic [1:0]        r_sel;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CTRL_W-1:0] r_cmd;
  logic [1:0]        r_cnt;
  logic              r_done;
  logic              r_ill;
  logic [1:0]        w_sel;
  logic [CTRL_W-1:0] w_cmd;
  always_comb begin
    w_sel = (i_req_op == 3'd5) ? 2'b00 : (i_req_op == 3'd3 || i_req_op == 3'd4) ? 2'b11 : 2'b10;
    w_cmd = (i_req_op == 3'd1) ? CTRL_W'(3) : (i_req_op == 3'd2 || i_req_op == 3'd4) ? CTRL_W'(4) : CTRL_W'(2);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_sel   <= 2'b00;
      r_ctrl  <= '0;
      r_cmd   <= '0;
      r_cnt   <= 2'd0;
      r_done  <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_ill  <= 1'b0;
      r_done <= 1'b0;
      if (r_state != IDLE && i_flush) begin
        r_state <= IDLE;
        r_sel   <= 2'b00;
        r_ctrl  <= '0;
      end else begin
        case (r_state)
          IDLE:
            if (i_req_valid) begin
              if (&i_req_op[2:1]) r_ill <= 1'b1;
              else begin
                r_state <= LOAD;
                r_sel   <= w_sel;
                r_cmd   <= w_cmd;
                r_ctrl  <= CTRL_W'(1);
              end
            end
          LOAD:
            if (SET_N == 2'd0) begin
              r_state <= SHIFT;
              r_ctrl  <= r_cmd;
            end else begin
              r_state <= WAIT;
              r_ctrl  <= '0;
              r_cnt   <= SET_N - 2'd1;
            end
          WAIT:
            if (r_cnt == 2'd0) begin
              r_state <= SHIFT;
              r_ctrl  <= r_cmd;
            end else r_cnt <= r_cnt - 2'd1;
          SHIFT: begin
            r_state <= DONE;
            r_ctrl  <= '0;
            r_done  <= 1'b1;
          end
          DONE: begin
            r_state <= IDLE;
            r_sel   <= 2'b00;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  // a flush landing in DONE cancels the write in that same cycle
  assign o_req_ready  = (r_state == IDLE);
  assign o_shift_sel  = r_sel;
  assign o_shift_ctrl = r_ctrl;
  assign o_done       = r_done & ~i_flush;
  assign o_reg_wr     = r_done & ~i_flush;
  assign o_illegal    = r_ill;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed stimulus with a completion scoreboard for SETTLE=0, 2 and clamped 5.
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic va, vb, fla;
  logic [2:0] opa, opb;
  logic a_rdy, a_rw, a_done, a_ill, b_rdy, b_rw, b_done, b_ill, c_rdy, c_rw, c_done, c_ill;
  logic [1:0] a_sel, b_sel, c_sel;
  logic [2:0] a_ctrl, b_ctrl, c_ctrl;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct {bit ill; logic [1:0] sel; int cyc;} exp_t;
  exp_t sb[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_seq_ctrl #(.SETTLE(0), .CTRL_W(3)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(va), .i_req_op(opa), .i_flush(fla),
    .o_req_ready(a_rdy), .o_shift_sel(a_sel), .o_shift_ctrl(a_ctrl),
    .o_reg_wr(a_rw), .o_done(a_done), .o_illegal(a_ill));
  shift_seq_ctrl #(.SETTLE(2), .CTRL_W(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vb), .i_req_op(opb), .i_flush(1'b0),
    .o_req_ready(b_rdy), .o_shift_sel(b_sel), .o_shift_ctrl(b_ctrl),
    .o_reg_wr(b_rw), .o_done(b_done), .o_illegal(b_ill));
  shift_seq_ctrl #(.SETTLE(5), .CTRL_W(3)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vb), .i_req_op(opb), .i_flush(1'b0),
    .o_req_ready(c_rdy), .o_shift_sel(c_sel), .o_shift_ctrl(c_ctrl),
    .o_reg_wr(c_rw), .o_done(c_done), .o_illegal(c_ill));

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input bit il, input logic [1:0] s, input int c);
    exp_t e;
    e.ill = il;
    e.sel = s;
    e.cyc = c;
    sb[k].push_back(e);
  endtask

  task automatic mon(input int k, input logic d, input logic il, input logic [1:0] s, input logic rw);
    exp_t e;
    if (d || il) begin
      if (sb[k].size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb%0d unexpected: done=%0b illegal=%0b at cyc %0d, expected nothing", k, d, il, cyc);
      end else begin
        e = sb[k].pop_front();
        chk($sformatf("sb%0d kind", k), int'(il), int'(e.ill));
        chk($sformatf("sb%0d cycle", k), cyc, e.cyc);
        if (!il) begin
          chk($sformatf("sb%0d sel", k), int'(s), int'(e.sel));
          chk($sformatf("sb%0d reg_wr", k), int'(rw), 1);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_done, a_ill, a_sel, a_rw);
    mon(1, b_done, b_ill, b_sel, b_rw);
    mon(2, c_done, c_ill, c_sel, c_rw);
  end

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic a_idle(input string n);
    chk({n, " sel"}, int'(a_sel), 0);
    chk({n, " ctrl"}, int'(a_ctrl), 0);
    chk({n, " reg_wr"}, int'(a_rw), 0);
    chk({n, " done"}, int'(a_done), 0);
    chk({n, " ready"}, int'(a_rdy), 1);
  endtask

  initial begin
    rst_n = 1'b0; va = 1'b0; vb = 1'b0; fla = 1'b0; opa = 3'd0; opb = 3'd0;
    repeat (2) nc();
    a_idle("reset");
    chk("reset illegal", int'(a_ill), 0);
    chk("reset b ctrl", int'(b_ctrl), 0);
    #1 rst_n = 1'b1;
    // SLL with SETTLE=0; op changes after accept are ignored
    nc(); chk("t1 ready", int'(a_rdy), 1);
    #1 va = 1'b1; opa = 3'd0; push(0, 0, 2'b10, cyc + 3);
    nc(); chk("t1 c1 sel", int'(a_sel), 2); chk("t1 c1 ctrl", int'(a_ctrl), 1); chk("t1 c1 ready", int'(a_rdy), 0);
    #1 va = 1'b0; opa = 3'd1;
    nc(); chk("t1 c2 ctrl", int'(a_ctrl), 2); chk("t1 c2 sel", int'(a_sel), 2);
    nc(); chk("t1 c3 ctrl", int'(a_ctrl), 0); chk("t1 c3 done", int'(a_done), 1); chk("t1 c3 sel", int'(a_sel), 2);
    nc(); a_idle("t1 c4");
    // LUI then SRAV with valid held
    #1 va = 1'b1; opa = 3'd5; push(0, 0, 2'b00, cyc + 3);
    nc(); chk("t2 lui load", int'(a_ctrl), 1); chk("t2 lui sel", int'(a_sel), 0);
    #1 opa = 3'd4;
    nc(); chk("t2 lui shift", int'(a_ctrl), 2);
    nc(); chk("t2 lui done", int'(a_done), 1); chk("t2 c3 ready", int'(a_rdy), 0);
    nc(); chk("t2 c4 ready", int'(a_rdy), 1); push(0, 0, 2'b11, cyc + 3);
    nc(); chk("t2 srav sel", int'(a_sel), 3); chk("t2 srav load", int'(a_ctrl), 1);
    #1 va = 1'b0;
    nc(); chk("t2 srav shift", int'(a_ctrl), 4); chk("t2 c6 sel", int'(a_sel), 3);
    nc(); chk("t2 srav done", int'(a_done), 1);
    nc(); a_idle("t2 end");
    // illegal ops stay in IDLE
    #1 va = 1'b1; opa = 3'd6; push(0, 1, 2'b00, cyc + 1);
    nc(); chk("t3 illegal", int'(a_ill), 1); chk("t3 ready", int'(a_rdy), 1); chk("t3 ctrl", int'(a_ctrl), 0);
    #1 opa = 3'd7; push(0, 1, 2'b00, cyc + 1);
    nc(); chk("t3 illegal 111", int'(a_ill), 1); chk("t3 reg_wr", int'(a_rw), 0);
    #1 va = 1'b0;
    nc(); chk("t3 illegal low", int'(a_ill), 0); a_idle("t3 end");
    // flush in SHIFT for SLLV, new SRL accepted right after
    #1 va = 1'b1; opa = 3'd3;
    nc(); chk("t5 sel", int'(a_sel), 3); chk("t5 load", int'(a_ctrl), 1);
    #1 va = 1'b0;
    nc(); chk("t5 shift", int'(a_ctrl), 2);
    #1 fla = 1'b1; va = 1'b1; opa = 3'd1;
    nc(); a_idle("t5 c3");
    #1 fla = 1'b0; push(0, 0, 2'b10, cyc + 3);
    nc(); chk("t5 srl load", int'(a_ctrl), 1); chk("t5 srl sel", int'(a_sel), 2);
    #1 va = 1'b0;
    nc(); chk("t5 srl shift", int'(a_ctrl), 3);
    nc(); nc(); a_idle("t5 end");
    // flush during DONE suppresses the write in that cycle
    #1 va = 1'b1; opa = 3'd0;
    nc(); #1 va = 1'b0;
    nc(); chk("fd shift", int'(a_ctrl), 2);
    @(posedge clk); #1 fla = 1'b1;
    nc(); chk("fd done", int'(a_done), 0); chk("fd reg_wr", int'(a_rw), 0);
    #1 fla = 1'b0;
    nc(); a_idle("fd end");
    // flush in IDLE does not block accept
    #1 va = 1'b1; fla = 1'b1; opa = 3'd2; push(0, 0, 2'b10, cyc + 3);
    nc(); chk("fi load", int'(a_ctrl), 1); chk("fi sel", int'(a_sel), 2);
    #1 va = 1'b0; fla = 1'b0;
    nc(); chk("fi shift", int'(a_ctrl), 4);
    nc(); nc();
    // async reset during LOAD
    #1 va = 1'b1; opa = 3'd0;
    nc(); chk("rs load", int'(a_ctrl), 1);
    #1 va = 1'b0;
    #1 rst_n = 1'b0;
    #1 a_idle("rs async");
    nc(); #1 rst_n = 1'b1;
    repeat (4) begin
      nc(); chk("rs no done", int'(a_done), 0); chk("rs ctrl", int'(a_ctrl), 0);
    end
    chk("rs ready", int'(a_rdy), 1);
    // SRL with SETTLE=2 (dut_b) and SETTLE=5 clamped to 3 (dut_c)
    #1 vb = 1'b1; opb = 3'd1; push(1, 0, 2'b10, cyc + 5); push(2, 0, 2'b10, cyc + 6);
    nc(); chk("t4 load", int'(b_ctrl), 1); chk("t4 sel c1", int'(b_sel), 2);
    #1 vb = 1'b0;
    nc(); chk("t4 nop c2", int'(b_ctrl), 0); chk("t4 sel c2", int'(b_sel), 2);
    nc(); chk("t4 nop c3", int'(b_ctrl), 0); chk("t4 sel c3", int'(b_sel), 2);
    nc(); chk("t4 shift c4", int'(b_ctrl), 3); chk("clamp nop c4", int'(c_ctrl), 0);
    nc(); chk("t4 done c5", int'(b_done), 1); chk("t4 sel c5", int'(b_sel), 2); chk("clamp shift c5", int'(c_ctrl), 3);
    nc(); chk("t4 ready c6", int'(b_rdy), 1); chk("t4 sel c6", int'(b_sel), 0); chk("clamp done c6", int'(c_done), 1);
    nc(); chk("clamp ready", int'(c_rdy), 1);
    for (int k = 0; k < 3; k++) chk($sformatf("sb%0d leftover", k), sb[k].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
